// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for a 4:1 mux: steps the select lines through 0..3, samples the
// mux output after a settle time, and hands the 4-bit word out on valid/ready.
// Optional registered parity output when MUX_SCAN_PARITY_EN is defined.
module mux_scan_sequencer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       addr0,
    output logic       addr1,
    input  logic       mux_out,
    output logic [3:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic       parity
`endif
);

    // A settle time of 0 behaves as 1; the counter is 4 bits wide, so cap at 15.
    localparam int SETTLE_EFF = (SETTLE_CYCLES < 1)  ? 1  :
                                (SETTLE_CYCLES > 15) ? 15 : SETTLE_CYCLES;
    localparam logic [3:0] CNT_LAST = 4'(SETTLE_EFF - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] addr, addr_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [3:0] data_nxt;
    logic       valid_nxt, busy_nxt;
    logic       sample;

    assign sample = (cnt == CNT_LAST);
    assign addr0  = addr[0];
    assign addr1  = addr[1];

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        cnt_nxt   = cnt;
        data_nxt  = data;
        valid_nxt = valid;
        busy_nxt  = busy;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = DRIVE;
                    addr_nxt  = 2'd0;
                    cnt_nxt   = 4'd0;
                    busy_nxt  = 1'b1;
                end
            end
            DRIVE: begin
                busy_nxt = 1'b1;
                if (sample) begin
                    // mux_out is captured as-is, including X/Z.
                    data_nxt[addr] = mux_out;
                    cnt_nxt        = 4'd0;
                    if (addr == 2'd3) begin
                        state_nxt = HOLD;
                        valid_nxt = 1'b1;
                        addr_nxt  = 2'd0;
                    end else begin
                        addr_nxt = addr + 2'd1;
                    end
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            HOLD: begin
                if (ready) begin
                    valid_nxt = 1'b0;
                    if (start) begin
                        // Back-to-back scan straight from the accept edge.
                        state_nxt = DRIVE;
                        addr_nxt  = 2'd0;
                        cnt_nxt   = 4'd0;
                        busy_nxt  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                addr_nxt  = 2'd0;
                cnt_nxt   = 4'd0;
                valid_nxt = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            addr  <= 2'd0;
            cnt   <= 4'd0;
            data  <= 4'b0000;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
            cnt   <= cnt_nxt;
            data  <= data_nxt;
            valid <= valid_nxt;
            busy  <= busy_nxt;
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) parity <= 1'b0;
        else        parity <= ^data_nxt;
    end
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Randomized self-checking bench for mux_scan_sequencer against a cycle-count
// reference model of the scan (address = elapsed cycles / settle time).
module tb_mux_scan_sequencer;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_n, start, ready, mux_out;
    logic       addr0, addr1, valid, busy;
    logic [3:0] data;
    logic [3:0] mux_in;
`ifdef MUX_SCAN_PARITY_EN
    logic       parity;
`endif

    assign mux_out = mux_in[{addr1, addr0}];

    mux_scan_sequencer #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .addr0(addr0), .addr1(addr1), .mux_out(mux_out),
        .data(data), .valid(valid), .ready(ready), .busy(busy)
`ifdef MUX_SCAN_PARITY_EN
        , .parity(parity)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // reference model: scanning for m_t cycles, or holding a finished word
    bit         m_scan, m_hold, m_acc;
    int         m_t;
    logic [3:0] m_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_scan = 0; m_hold = 0; m_acc = 0; m_t = 0; m_data = 4'b0000;
    endtask

    task automatic model_edge(input logic st, input logic rd);
        m_acc = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_scan) begin
            if (m_t % S == S - 1) m_data[m_t / S] = mux_in[m_t / S];
            m_t++;
            if (m_t == 4 * S) begin
                m_scan = 0;
                m_hold = 1;
            end
        end else if (m_hold) begin
            if (rd) begin
                m_hold = 0;
                m_acc  = 1;
                if (st) begin m_scan = 1; m_t = 0; end
            end
        end else if (st) begin
            m_scan = 1; m_t = 0;
        end
    endtask

    function automatic logic [1:0] m_addr();
        return m_scan ? 2'(m_t / S) : 2'd0;
    endfunction

    task automatic check_all();
        chk("addr",  {30'd0, addr1, addr0}, {30'd0, m_addr()});
        chk("valid", {31'd0, valid}, {31'd0, m_hold});
        chk("busy",  {31'd0, busy},  {31'd0, m_scan | m_hold});
        chk("data",  {28'd0, data},  {28'd0, m_data});
`ifdef MUX_SCAN_PARITY_EN
        if (m_hold) chk("parity", {31'd0, parity}, {31'd0, ^m_data});
`endif
    endtask

    task automatic cyc(input logic st, input logic rd);
        @(negedge clk);
        start = st;
        ready = rd;
        @(posedge clk);
        model_edge(st, rd);
        #1;
        check_all();
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; ready = 1'b0; mux_in = 4'b0000;
        model_reset();

        // reset, then idle with start low
        repeat (3) cyc(0, 0);
        rst_n = 1'b1;
        repeat (10) cyc(0, 0);

        // basic scan, in0..in3 = 1,0,1,1
        mux_in = 4'b1101;
        cyc(1, 1);
        n = 0;
        while (!valid && n < 40) begin cyc(0, 1); n++; end
        chk("lat", n, 4 * S);
        chk("word", {28'd0, data}, 32'hd);
        cyc(0, 1);
        chk("acc_busy", {31'd0, busy}, 32'd0);
        repeat (2) cyc(0, 1);

        // backpressure
        cyc(1, 0);
        n = 0;
        while (!valid && n < 40) begin cyc(0, 0); n++; end
        chk("bp_lat", n, 4 * S);
        repeat (5) cyc(0, 0);
        chk("bp_data", {28'd0, data}, 32'hd);
        cyc(0, 1);
        chk("bp_acc", {31'd0, valid}, 32'd0);

        // back-to-back with start held; inputs change after first accept
        n = 0;
        while (n < 60) begin
            cyc(1, 1);
            n++;
            if (m_acc) begin
                mux_in = 4'b0010;
                break;
            end
        end
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        n = 0;
        while (!valid && n < 40) begin cyc(1, 0); n++; end
        chk("b2b_lat", n, 4 * S);
        chk("b2b_word", {28'd0, data}, 32'h2);
        cyc(0, 1);
        repeat (2) cyc(0, 0);

        // start during DRIVE at address 2 is ignored
        mux_in = 4'b0110;
        cyc(1, 0);
        n = 0;
        while (!(m_scan && m_t / S == 2) && n < 40) begin cyc(0, 0); n++; end
        cyc(1, 0);
        n = 0;
        while (!valid && n < 40) begin cyc(0, 0); n++; end
        chk("ign_lat", n, S * 2 - 1);
        cyc(0, 1);
        repeat (3) cyc(0, 0);

        // X on mux_out is captured unfiltered
        mux_in = 4'b1x01;
        cyc(1, 1);
        repeat (4 * S + 2) cyc(0, 1);

        // asynchronous reset mid-scan at address 1
        mux_in = 4'b1011;
        cyc(1, 0);
        n = 0;
        while (!(m_scan && m_t / S == 1) && n < 40) begin cyc(0, 0); n++; end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_addr",  {30'd0, addr1, addr0}, 32'd0);
        chk("arst_valid", {31'd0, valid}, 32'd0);
        chk("arst_busy",  {31'd0, busy}, 32'd0);
        chk("arst_data",  {28'd0, data}, 32'd0);
        repeat (2) cyc(0, 0);
        rst_n = 1'b1;
        repeat (4 * S + 4) cyc(0, 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            mux_in = 4'($urandom_range(0, 15));
            cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
